ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB-Lite slave memory that consumes the master-side transfer signals (HADDR, HWDATA, HWRITE, HSIZE, HBURST, HTRANS).
- Produces the slave responses HRDATA, HREADYOUT and HRESP.
- Serves as the RTL responder sitting directly downstream of the AHB bus in block- and subsystem-level benches.
- Supports word-addressed storage, byte and halfword write lanes, two-cycle ERROR responses and optional wait-state insertion.

Parameters:
- ADDR_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA width. Fixed at 32 for this revision.
- MEM_DEPTH, 1024, number of DATA_WIDTH words. Valid byte range is 0 to MEM_DEPTH*4-1.
- WAIT_STATES, 2, wait cycles per transfer. Used only when AHB_SLV_WAIT_EN is defined. Range 0-15.

Ports:
- HCLK  input  1  bus clock; all logic is on the rising edge.
- HRESET  input  1  synchronous active-high reset.
- HSEL  input  1  slave select.
- HADDR  input  ADDR_WIDTH  transfer address.
- HWDATA  input  DATA_WIDTH  write data, valid in the data phase.
- HWRITE  input  1  1=write, 0=read.
- HSIZE  input  3  transfer size: 0=byte, 1=half, 2=word.
- HBURST  input  3  burst type. Accepted but ignored; each beat is handled independently.
- HTRANS  input  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
- HREADY  input  1  bus-level ready (combined HREADYOUT of all slaves).
- HREADYOUT  output  1  slave ready.
- HRESP  output  1  0=OKAY, 1=ERROR.
- HRDATA  output  DATA_WIDTH  read data.

Behaviour:
- Reset values (at HCLK edge with HRESET=1): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, no pending write. Memory contents are not reset.
- Reset mid-transfer: the pending data phase is abandoned and no memory write is committed.
- Address-phase accept: HSEL && HREADY && HTRANS[1]. On accept, register addr, write, size and error flag.
- Inputs that do not produce an accept (IDLE, BUSY, or unselected) get zero-wait OKAY.
- Error flag is set when any of these hold:
  - HADDR >= MEM_DEPTH*4;
  - HSIZE > 2;
  - misaligned access: half with HADDR[0]=1, or word with HADDR[1:0]!=0.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE -> DATA on accept when there are no waits and no error.
  - IDLE -> WAIT on accept when waits > 0.
  - IDLE -> ERR1 on accept with the error flag set. Errors take precedence over waits.
  - WAIT: HREADYOUT=0, HRESP=0. Decrement counter; -> DATA when the counter reaches 0.
  - DATA: HREADYOUT=1, HRESP=0. Commit the write or present read data. Back-to-back accept in the same cycle re-enters WAIT, ERR1 or DATA accordingly; otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. -> IDLE, or re-accept.
  - Errored writes never modify memory. Errored reads drive HRDATA=0.
- Write lanes:
  - byte: lane HADDR[1:0];
  - half: lanes {HADDR[1],0} and {HADDR[1],1};
  - word: all lanes.
  - Data is taken from the matching HWDATA byte lanes, committed in the final data-phase cycle (HREADYOUT=1).
- Reads: HRDATA carries the full addressed word, valid in the cycle HREADYOUT=1. In all other cycles HRDATA holds its previous value.
- Read-after-write hazard: a read address phase that overlaps the data phase of a write to the same word must return the merged, newly written bytes (bypass).
- Zero-wait latency: address phase in cycle N, data/response in cycle N+1. Full pipelined throughput is one transfer per cycle.
- A master driving HTRANS=IDLE mid-burst gets OKAY with no access.

Optional Feature:
- Macro: AHB_SLV_WAIT_EN.
- Defined: every accepted, non-error transfer inserts WAIT_STATES cycles of HREADYOUT=0 before its DATA cycle.
- Undefined: wait count is 0; WAIT is unreachable and optimised out. WAIT_STATES is ignored.

Test Plan:
- Reset with HRESET=1 for 2 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0x0000_0000.
- Word write 0xDEADBEEF @0x10, then word read @0x10 back-to-back (macro undefined) -> read data phase HRDATA=0xDEADBEEF, zero waits (bypass path).
- Byte write 0xAA @0x13 over word 0x11223344 @0x10, then read @0x10 -> HRDATA=0xAA223344.
- Word read @0x1000 (MEM_DEPTH=1024) -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1). A following write @0x1000 leaves memory unchanged.
- AHB_SLV_WAIT_EN defined, WAIT_STATES=2, 4-beat INCR4 word writes @0x0 -> each beat shows exactly 2 cycles HREADYOUT=0 then 1 cycle HREADYOUT=1; readback returns all 4 words.
- HRESET asserted during the data phase of a write 0x55 @0x20 -> word @0x20 keeps its prior value 0x0.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// rtl/ahb_sram_slave_if.sv - AHB-Lite transfer/response bundle between a master and the SRAM slave
interface ahb_sram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [1:0]            HTRANS;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [DATA_WIDTH-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HTRANS, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HTRANS, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite word SRAM slave with byte/half lanes, ERROR responses, optional waits
// Wait-state insertion is enabled by defining AHB_SLV_WAIT_EN.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 2
) (
    input logic HCLK,
    input logic HRESET,
    ahb_sram_slave_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_DEPTH * 4);
`ifdef AHB_SLV_WAIT_EN
    localparam logic [3:0] WAITS = 4'(WAIT_STATES);
`else
    localparam logic [3:0] WAITS = 4'd0;
`endif

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t               state, state_next;
    logic [3:0]           cnt, cnt_next;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [IDX_W-1:0]     a_idx;
    logic [1:0]           a_off;
    logic                 a_write;
    logic [2:0]           a_size;
    logic [DATA_WIDTH-1:0] rdata, rd_value, merged;
    logic [IDX_W-1:0]     in_idx;
    logic [3:0]           wr_be;
    logic                 accept, in_err, start, capture, commit, rd_load, rd_clear;
    logic                 unused_ok;

    function automatic logic [3:0] lanes(input logic [2:0] size, input logic [1:0] off);
        case (size)
            3'd0:    lanes = 4'b0001 << off;
            3'd1:    lanes = off[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    endfunction

    assign unused_ok = ^{bus.HBURST, bus.HTRANS[0]};

    assign accept = bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign in_err = (bus.HADDR >= ADDR_LIMIT) || (bus.HSIZE > 3'd2)
                 || (bus.HSIZE == 3'd1 && bus.HADDR[0])
                 || (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00);
    assign in_idx = bus.HADDR[IDX_W+1:2];
    assign wr_be  = lanes(a_size, a_off);
    assign commit = (state == ST_DATA) && a_write;
    assign start  = accept && (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);

    // Word as it will look after this cycle's write lands; also feeds the read bypass.
    always_comb begin
        merged = mem[a_idx];
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) merged[8*b +: 8] = bus.HWDATA[8*b +: 8];
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        rd_load    = 1'b0;
        rd_clear   = 1'b0;
        rd_value   = mem[a_idx];
        case (state)
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = ST_DATA;
                    rd_load    = !a_write;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_ERR1:          state_next = ST_ERR2;
            ST_DATA, ST_ERR2: state_next = ST_IDLE;
            default:          ;
        endcase
        if (start) begin
            capture = 1'b1;
            if (in_err) begin
                state_next = ST_ERR1;
                rd_clear   = !bus.HWRITE;
            end else if (WAITS != 4'd0) begin
                state_next = ST_WAIT;
                cnt_next   = WAITS - 4'd1;
            end else begin
                state_next = ST_DATA;
                rd_load    = !bus.HWRITE;
                rd_value   = (commit && a_idx == in_idx) ? merged : mem[in_idx];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            rdata   <= '0;
            a_idx   <= '0;
            a_off   <= 2'b00;
            a_write <= 1'b0;
            a_size  <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (rd_load)       rdata <= rd_value;
            else if (rd_clear) rdata <= '0;
            if (capture) begin
                a_idx   <= in_idx;
                a_off   <= bus.HADDR[1:0];
                a_write <= bus.HWRITE;
                a_size  <= bus.HSIZE;
            end
        end
    end

    // A reset landing on the data phase drops the write.
    always_ff @(posedge HCLK) begin
        if (!HRESET && commit) mem[a_idx] <= merged;
    end

    assign bus.HREADYOUT = !(state == ST_WAIT || state == ST_ERR1);
    assign bus.HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
    assign bus.HRDATA    = rdata;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed pipelined AHB bench with in-order scoreboard for ahb_sram_slave
module tb_ahb_sram_slave;
    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    assign bus.HREADY = bus.HREADYOUT;

    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
    );

`ifdef AHB_SLV_WAIT_EN
    localparam int EXP_WAITS = 2;
`else
    localparam int EXP_WAITS = 0;
`endif

    typedef struct {
        logic        act;
        logic        sel;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        logic        rd;
        logic        err;
        logic [31:0] data;
        int          waits;
    } exp_t;

    xfer_t       seq[$];
    exp_t        sb[$];
    logic [31:0] mdl [1024];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic add(input logic sel, input logic [1:0] trans, input logic [2:0] burst,
                       input logic write, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
        xfer_t x;
        x.act = sel && trans[1];
        x.sel = sel; x.trans = trans; x.burst = burst; x.write = write;
        x.size = size; x.addr = addr; x.wdata = wdata;
        seq.push_back(x);
    endtask

    // Expected outcome computed when the address phase goes out; transfers complete in order.
    task automatic issue(input xfer_t x);
        exp_t       e;
        logic [3:0] be;
        int         idx;
        if (!x.act) return;
        e.err = (x.addr >= 32'h1000) || (x.size > 3'd2)
             || (x.size == 3'd1 && x.addr[0]) || (x.size == 3'd2 && x.addr[1:0] != 2'b00);
        e.rd    = !x.write;
        e.waits = e.err ? 1 : EXP_WAITS;
        e.data  = 32'h0;
        idx     = int'(x.addr[11:2]);
        be      = 4'b0000;
        if (!e.err) begin
            if (x.write) begin
                case (x.size)
                    3'd0:    be = 4'b0001 << x.addr[1:0];
                    3'd1:    be = x.addr[1] ? 4'b1100 : 4'b0011;
                    default: be = 4'b1111;
                endcase
                for (int b = 0; b < 4; b++) if (be[b]) mdl[idx][8*b +: 8] = x.wdata[8*b +: 8];
            end else begin
                e.data = mdl[idx];
            end
        end
        sb.push_back(e);
    endtask

    task automatic drive_addr(input int ap);
        if (ap >= 0) begin
            bus.HSEL = seq[ap].sel;     bus.HTRANS = seq[ap].trans; bus.HBURST = seq[ap].burst;
            bus.HWRITE = seq[ap].write; bus.HSIZE = seq[ap].size;   bus.HADDR = seq[ap].addr;
        end else begin
            bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HBURST = 3'd0;
            bus.HWRITE = 1'b0; bus.HSIZE = 3'd2; bus.HADDR = 32'h0;
        end
    endtask

    task automatic run_seq(input string name);
        int   ap = -1, dp = -1, prev_ap = -1, nxt = 0, waits = 0, resp_w = 0, cyc = 0;
        logic prev_h = 1'b1, h, done = 1'b0;
        exp_t e;
        while (!done && cyc < 400) begin
            @(posedge HCLK); #1; cyc++;
            if (prev_h) begin dp = prev_ap; waits = 0; resp_w = 0; end
            h = bus.HREADYOUT;
            if (dp >= 0 && seq[dp].act) begin
                if (!h) begin
                    waits++;
                    if (bus.HRESP) resp_w++;
                end else begin
                    e = sb.pop_front();
                    check($sformatf("%s_%0d_resp", name, dp), {31'b0, bus.HRESP}, {31'b0, e.err});
                    check($sformatf("%s_%0d_waits", name, dp), 32'(waits), 32'(e.waits));
                    if (e.err) check($sformatf("%s_%0d_err1", name, dp), 32'(resp_w), 32'd1);
                    if (e.rd) check($sformatf("%s_%0d_rdata", name, dp), bus.HRDATA, e.data);
                end
            end
            if (prev_h) begin
                if (nxt < seq.size()) begin ap = nxt; nxt++; issue(seq[ap]); end
                else ap = -1;
            end
            drive_addr(ap);
            bus.HWDATA = (dp >= 0) ? seq[dp].wdata : 32'h0;
            if (h && ap < 0 && nxt >= seq.size()) done = 1'b1;
            prev_h = h; prev_ap = ap;
        end
        check($sformatf("%s_complete", name), {31'b0, done}, 32'd1);
        seq.delete();
        sb.delete();
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_hreadyout"}, {31'b0, bus.HREADYOUT}, 32'd1);
        check({name, "_hresp"}, {31'b0, bus.HRESP}, 32'd0);
        check({name, "_hrdata"}, bus.HRDATA, 32'h0);
    endtask

    initial begin
        HRESET = 1'b1;
        drive_addr(-1);
        bus.HWDATA = 32'h0;
        repeat (2) @(posedge HCLK);
        #1;
        check_reset_values("reset");
        HRESET = 1'b0;

        // Write then read the same word back-to-back.
        add(1, 2'b10, 3'd0, 1, 3'd2, 32'h10, 32'hDEADBEEF);
        add(1, 2'b10, 3'd0, 0, 3'd2, 32'h10, 32'h0);
        run_seq("bypass");

        // Byte and halfword lanes.
        add(1, 2'b10, 3'd0, 1, 3'd2, 32'h10, 32'h11223344);
        add(1, 2'b10, 3'd0, 1, 3'd0, 32'h13, 32'hAABBCCDD);
        add(1, 2'b10, 3'd0, 0, 3'd2, 32'h10, 32'h0);
        add(1, 2'b10, 3'd0, 1, 3'd2, 32'h14, 32'h0);
        add(1, 2'b10, 3'd0, 1, 3'd1, 32'h16, 32'h55667788);
        add(1, 2'b10, 3'd0, 1, 3'd0, 32'h14, 32'h000000E1);
        add(1, 2'b10, 3'd0, 0, 3'd2, 32'h14, 32'h0);
        run_seq("lanes");

        // Error responses, aliasing check, unselected and IDLE/BUSY slots.
        add(1, 2'b10, 3'd0, 1, 3'd2, 32'h0, 32'hCAFEF00D);
        add(1, 2'b10, 3'd0, 0, 3'd2, 32'h1000, 32'h0);
        add(1, 2'b10, 3'd0, 1, 3'd2, 32'h1000, 32'h12345678);
        add(1, 2'b10, 3'd0, 0, 3'd2, 32'h0, 32'h0);
        add(1, 2'b10, 3'd0, 0, 3'd1, 32'h11, 32'h0);
        add(1, 2'b10, 3'd0, 1, 3'd2, 32'h12, 32'hFFFFFFFF);
        add(1, 2'b10, 3'd0, 0, 3'd3, 32'h10, 32'h0);
        add(1, 2'b10, 3'd0, 1, 3'd2, 32'hFFC, 32'h0BADC0DE);
        add(0, 2'b10, 3'd0, 1, 3'd2, 32'h0, 32'hFFFFFFFF);
        add(1, 2'b00, 3'd0, 1, 3'd2, 32'h0, 32'hFFFFFFFF);
        add(1, 2'b01, 3'd0, 1, 3'd2, 32'h0, 32'hFFFFFFFF);
        add(1, 2'b10, 3'd0, 0, 3'd2, 32'hFFC, 32'h0);
        add(1, 2'b10, 3'd0, 0, 3'd2, 32'h0, 32'h0);
        add(1, 2'b10, 3'd0, 0, 3'd2, 32'h10, 32'h0);
        run_seq("errors");

        // INCR4 writes then INCR4 reads from 0x0.
        for (int i = 0; i < 4; i++)
            add(1, (i == 0) ? 2'b10 : 2'b11, 3'b011, 1, 3'd2, 32'(4 * i), 32'hA0B0C000 + 32'(i));
        for (int i = 0; i < 4; i++)
            add(1, (i == 0) ? 2'b10 : 2'b11, 3'b011, 0, 3'd2, 32'(4 * i), 32'h0);
        run_seq("incr4");

        // Reset during the data phase of a write must drop it.
        add(1, 2'b10, 3'd0, 1, 3'd2, 32'h20, 32'h0);
        run_seq("pre_reset");
        @(posedge HCLK); #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HSIZE = 3'd2; bus.HADDR = 32'h20;
        @(posedge HCLK); #1;
        drive_addr(-1);
        bus.HWDATA = 32'h55;
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        check_reset_values("midreset");
        add(1, 2'b10, 3'd0, 0, 3'd2, 32'h20, 32'h0);
        run_seq("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
